// File: rtl/pps_source_timer.sv
// PPS front end: synchronises three GPS PPS pins, selects one (or a software strobe),
// regenerates a fixed-width pulse and optional burst, and measures the PPS period.
module pps_source_timer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned BURST_COUNT = 8,
  parameter logic [27:0] MISS_LIMIT  = 28'd40000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        pps_a_i,
  input  logic        pps_b_i,
  input  logic        pps_g_i,
  output logic        pps_o,
  output logic        pps_burst_o,
  output logic        pps_missing_o
);

  localparam logic [27:0] LIVE_MAX   = 28'hFFFFFFF;
  localparam logic [27:0] MISS_AT    = MISS_LIMIT - 28'd1;
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0]  BURST_LAST = 8'(BURST_COUNT - 1);

  typedef enum logic {P_IDLE, P_HIGH} pulse_state_t;
  typedef enum logic [1:0] {B_IDLE, B_HI, B_LO} burst_state_t;

  logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b, r_sync_g;
  logic [3:0]  w_lvl;
  logic        w_wr0, w_clr, w_edge, w_unused;
  logic [1:0]  r_sel;
  logic        r_burst_en, r_sw, r_prev, r_edge;
  logic [27:0] r_live, r_period;
  logic [15:0] r_count;
  logic        r_missing;
  pulse_state_t r_pstate, w_pstate_nxt;
  burst_state_t r_bstate, w_bstate_nxt;
  logic [7:0]  r_pcnt, r_bcnt;

  // Pins are asynchronous; only the last stage of each chain is used downstream.
  always_ff @(posedge clk_i) begin
    r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], pps_a_i};
    r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], pps_b_i};
    r_sync_g <= {r_sync_g[SYNC_STAGES-2:0], pps_g_i};
  end

  assign w_lvl = {1'b0, r_sync_g[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1], r_sync_a[SYNC_STAGES-1]};

  // wr_i is a single-cycle strobe with no back-pressure; only address 0 is writable.
  assign w_wr0    = wr_i && (addr_i == 2'd0);
  assign w_clr    = w_wr0 && dat_i[4];
  assign w_edge   = (r_sel == 2'd3) ? r_sw : (w_lvl[r_sel] & ~r_prev);
  assign w_unused = ^dat_i[31:5];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel      <= 2'd0;
      r_burst_en <= 1'b0;
      r_sw       <= 1'b0;
      r_prev     <= w_lvl[0];
      r_edge     <= 1'b0;
    end else begin
      r_sw   <= w_wr0 && (dat_i[1:0] == 2'd3) && dat_i[2];
      r_edge <= w_edge;
      if (w_wr0) begin
        r_sel      <= dat_i[1:0];
        r_burst_en <= dat_i[3];
        // Seed history from the new source so an already-high input is not an edge.
        r_prev     <= w_lvl[dat_i[1:0]];
      end else begin
        r_prev <= w_lvl[r_sel];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_clr) begin
      r_period  <= 28'd0;
      r_live    <= 28'd0;
      r_count   <= 16'd0;
      r_missing <= 1'b0;
    end else if (r_edge) begin
      r_period  <= (r_live == LIVE_MAX) ? LIVE_MAX : r_live + 28'd1;
      r_live    <= 28'd0;
      r_count   <= r_count + 16'd1;
      r_missing <= 1'b0;
    end else begin
      r_live <= (r_live == LIVE_MAX) ? LIVE_MAX : r_live + 28'd1;
      if (r_live == MISS_AT) r_missing <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pstate <= P_IDLE;
      r_pcnt   <= 8'd0;
    end else begin
      r_pstate <= w_pstate_nxt;
      r_pcnt   <= (r_pstate == P_HIGH) ? r_pcnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    w_pstate_nxt = r_pstate;
    case (r_pstate)
      P_IDLE:  if (r_edge) w_pstate_nxt = P_HIGH;
      P_HIGH:  if (r_pcnt == PULSE_LAST) w_pstate_nxt = P_IDLE;
      default: w_pstate_nxt = P_IDLE;
    endcase
  end

  always_comb begin
    pps_o = (r_pstate == P_HIGH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bstate <= B_IDLE;
      r_bcnt   <= 8'd0;
    end else begin
      r_bstate <= w_bstate_nxt;
      case (r_bstate)
        B_IDLE:  r_bcnt <= 8'd0;
        B_LO:    r_bcnt <= r_bcnt + 8'd1;
        default: r_bcnt <= r_bcnt;
      endcase
    end
  end

  // burst_en is only consulted at the start, so clearing it lets a running burst finish.
  always_comb begin
    w_bstate_nxt = r_bstate;
    case (r_bstate)
      B_IDLE:  if (r_edge && r_burst_en) w_bstate_nxt = B_HI;
      B_HI:    w_bstate_nxt = B_LO;
      B_LO:    w_bstate_nxt = (r_bcnt == BURST_LAST) ? B_IDLE : B_HI;
      default: w_bstate_nxt = B_IDLE;
    endcase
  end

  always_comb begin
    pps_burst_o = (r_bstate == B_HI);
  end

  assign pps_missing_o = r_missing;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o <= 32'd0;
    end else begin
      case (addr_i)
        2'd0:    dat_o <= {27'd0, r_missing, r_burst_en, 1'b0, r_sel};
        2'd1:    dat_o <= {4'd0, r_period};
        2'd2:    dat_o <= {16'd0, r_count};
        default: dat_o <= {4'd0, r_live};
      endcase
    end
  end

endmodule

// File: tb/tb_pps_source_timer.sv
// Bench for pps_source_timer: scenario tasks with randomized timing, checked against
// expectations derived from pin/strobe times (latency, pulse windows, cycle deltas).
module tb_pps_source_timer;

  localparam int SYNC_STAGES = 2;
  localparam int PULSE_LEN   = 4;
  localparam int BURST_COUNT = 8;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam logic [27:0] MISS_LIMIT = 28'd100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        pps_a_i = 1'b0, pps_b_i = 1'b0, pps_g_i = 1'b0;
  logic        pps_o, pps_burst_o, pps_missing_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  pps_source_timer #(
    .SYNC_STAGES(SYNC_STAGES), .PULSE_LEN(PULSE_LEN),
    .BURST_COUNT(BURST_COUNT), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .addr_i(addr_i), .dat_i(dat_i),
    .dat_o(dat_o), .pps_a_i(pps_a_i), .pps_b_i(pps_b_i), .pps_g_i(pps_g_i),
    .pps_o(pps_o), .pps_burst_o(pps_burst_o), .pps_missing_o(pps_missing_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] v);
    wr_i = 1'b1; addr_i = 2'd0; dat_i = v;
    step();
    wr_i = 1'b0; dat_i = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr_i = a;
    step();
    v = dat_o;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_i = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({pps_o, pps_burst_o, pps_missing_o} !== 3'b000) begin
      n_errors++; $display("FAIL reset_outputs: got %b expected 000", {pps_o, pps_burst_o, pps_missing_o});
    end
    addr_i = 2'd3; rst_i = 1'b0;
    step();
    n_checks++;
    if (dat_o > 32'd2) begin
      n_errors++; $display("FAIL reset_live: got %0d expected <=2", dat_o);
    end
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_errors++; $display("FAIL reset_reg%0d: got %0h expected 0", a, v);
      end
    end
  endtask

  task automatic test_period();
    int rise_t[4];
    int gap, fall, t0;
    logic exp_p;
    logic [31:0] exp_per;
    wr(32'h10);
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(150, 400);
      fall = $urandom_range(3, 60);
      t0 = cyc;
      rise_t[i] = t0;
      if (i > 0) exp_q.push_back(32'(rise_t[i] - rise_t[i-1]));
      n_checks++;
      if (pps_o !== 1'b0) begin
        n_errors++; $display("FAIL period_idle: got %b expected 0", pps_o);
      end
      pps_a_i = 1'b1;
      for (int k = 1; k <= gap; k++) begin
        step();
        if (k <= 10) begin
          exp_p = (k >= LAT) && (k < LAT + PULSE_LEN);
          n_checks++;
          if (pps_o !== exp_p) begin
            n_errors++; $display("FAIL period_pulse edge%0d k%0d: got %b expected %b", i, k, pps_o, exp_p);
          end
        end
        if (k == fall) pps_a_i = 1'b0;
        if (k == 20) addr_i = 2'd1;
        if (k == 21) begin
          if (i > 0) begin
            exp_per = exp_q.pop_front();
            n_checks++;
            if (dat_o !== exp_per) begin
              n_errors++; $display("FAIL period_value edge%0d: got %0d expected %0d", i, dat_o, exp_per);
            end
          end
          addr_i = 2'd2;
        end
        if (k == 22) begin
          n_checks++;
          if (dat_o !== 32'(i + 1)) begin
            n_errors++; $display("FAIL period_count edge%0d: got %0d expected %0d", i, dat_o, i + 1);
          end
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [31:0] c0, v;
    int r2, s1, s2;
    logic p2_ok, exp_p, exp_b;
    wr(32'h9);
    rd(2'd2, c0);
    repeat (4) step();
    r2 = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 3) : $urandom_range(6, 12);
    s1 = LAT;
    s2 = r2 + LAT;
    p2_ok = (s2 >= s1 + PULSE_LEN);
    pps_b_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) pps_b_i = 1'b0;
      if (k == r2) pps_b_i = 1'b1;
      exp_p = ((k >= s1) && (k < s1 + PULSE_LEN)) || (p2_ok && (k >= s2) && (k < s2 + PULSE_LEN));
      exp_b = (k >= s1) && (k < s1 + 2 * BURST_COUNT) && (((k - s1) % 2) == 0);
      n_checks++;
      if (pps_o !== exp_p) begin
        n_errors++; $display("FAIL burst_pulse r%0d k%0d: got %b expected %b", r2, k, pps_o, exp_p);
      end
      n_checks++;
      if (pps_burst_o !== exp_b) begin
        n_errors++; $display("FAIL burst_train r%0d k%0d: got %b expected %b", r2, k, pps_burst_o, exp_b);
      end
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== c0 + 32'd2) begin
      n_errors++; $display("FAIL burst_count: got %0d expected %0d", v, c0 + 32'd2);
    end
    // burst_en dropped mid-burst: the running burst still completes
    pps_b_i = 1'b0;
    repeat (4) step();
    pps_b_i = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 7) begin wr_i = 1'b1; addr_i = 2'd0; dat_i = 32'h1; end
      if (k == 8) begin wr_i = 1'b0; dat_i = 32'd0; end
      exp_b = (k >= s1) && (k < s1 + 2 * BURST_COUNT) && (((k - s1) % 2) == 0);
      n_checks++;
      if (pps_burst_o !== exp_b) begin
        n_errors++; $display("FAIL burst_disable k%0d: got %b expected %b", k, pps_burst_o, exp_b);
      end
    end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_errors++; $display("FAIL burst_ctrl_read: got %0h expected 1", v);
    end
    pps_b_i = 1'b0;
  endtask

  task automatic test_missing();
    int w1, w2, extra;
    logic exp_m;
    logic [31:0] v;
    wr(32'h13);
    wr(32'h7);
    w1 = cyc;
    for (int k = 1; k <= 102; k++) begin
      step();
      if (k == 2 || k == 101 || k == 102) begin
        exp_m = (k >= 2 + int'(MISS_LIMIT));
        n_checks++;
        if (pps_missing_o !== exp_m) begin
          n_errors++; $display("FAIL missing_rise k%0d: got %b expected %b", k, pps_missing_o, exp_m);
        end
      end
    end
    extra = $urandom_range(0, 50);
    repeat (extra) step();
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h13) begin
      n_errors++; $display("FAIL missing_ctrl_read: got %0h expected 13", v);
    end
    wr(32'h7);
    w2 = cyc;
    step();
    n_checks++;
    if (pps_missing_o !== 1'b1) begin
      n_errors++; $display("FAIL missing_hold: got %b expected 1", pps_missing_o);
    end
    step();
    n_checks++;
    if (pps_missing_o !== 1'b0) begin
      n_errors++; $display("FAIL missing_clear: got %b expected 0", pps_missing_o);
    end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'(w2 - w1)) begin
      n_errors++; $display("FAIL missing_period: got %0d expected %0d", v, w2 - w1);
    end
  endtask

  task automatic test_sel_switch();
    logic [31:0] c0, v;
    logic exp_p;
    pps_g_i = 1'b1;
    repeat (5) step();
    rd(2'd2, c0);
    wr(32'h2);
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (pps_o !== 1'b0) begin
        n_errors++; $display("FAIL sel_g_high k%0d: got %b expected 0", k, pps_o);
      end
    end
    wr(32'h7);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_p = (k >= 2) && (k < 2 + PULSE_LEN);
      n_checks++;
      if (pps_o !== exp_p) begin
        n_errors++; $display("FAIL sel_sw_pulse k%0d: got %b expected %b", k, pps_o, exp_p);
      end
    end
    wr(32'h4);
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if (pps_o !== 1'b0) begin
        n_errors++; $display("FAIL sel_sw_ignored k%0d: got %b expected 0", k, pps_o);
      end
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== c0 + 32'd1) begin
      n_errors++; $display("FAIL sel_count: got %0d expected %0d", v, c0 + 32'd1);
    end
    pps_g_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    wr(32'h13);
    wr_i = 1'b1; addr_i = 2'd0; dat_i = 32'h7;
    repeat (65535) step();
    dat_i = 32'h3;
    step();
    wr_i = 1'b0; dat_i = 32'd0;
    repeat (4) step();
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'hFFFF) begin
      n_errors++; $display("FAIL wrap_full: got %0h expected ffff", v);
    end
    wr(32'h7);
    repeat (3) step();
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_errors++; $display("FAIL wrap_zero: got %0h expected 0", v);
    end
  endtask

  task automatic test_clear_edge();
    logic [31:0] v;
    int wc;
    wr(32'h7);
    step();
    repeat (6) step();
    wr(32'h7);
    step();
    wr(32'h13);
    wc = cyc;
    for (int k = 0; k <= PULSE_LEN; k++) begin
      n_checks++;
      if (pps_o !== (k < PULSE_LEN)) begin
        n_errors++; $display("FAIL clear_edge_pulse k%0d: got %b expected %b", k, pps_o, k < PULSE_LEN);
      end
      step();
    end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_errors++; $display("FAIL clear_edge_period: got %0d expected 0", v);
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_errors++; $display("FAIL clear_edge_count: got %0d expected 0", v);
    end
    rd(2'd3, v);
    n_checks++;
    if (v !== 32'(cyc - 1 - wc)) begin
      n_errors++; $display("FAIL clear_edge_live: got %0d expected %0d", v, cyc - 1 - wc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(32'hF);
    step();
    step();
    n_checks++;
    if ({pps_o, pps_burst_o} !== 2'b11) begin
      n_errors++; $display("FAIL reset_mid_start: got %b expected 11", {pps_o, pps_burst_o});
    end
    step();
    rst_i = 1'b1;
    step();
    n_checks++;
    if ({pps_o, pps_burst_o, pps_missing_o} !== 3'b000) begin
      n_errors++; $display("FAIL reset_mid_low: got %b expected 000", {pps_o, pps_burst_o, pps_missing_o});
    end
    rst_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if ({pps_o, pps_burst_o} !== 2'b00) begin
        n_errors++; $display("FAIL reset_mid_resume k%0d: got %b expected 00", k, {pps_o, pps_burst_o});
      end
    end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_errors++; $display("FAIL reset_mid_ctrl: got %0h expected 0", v);
    end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_period();
    test_burst();
    test_missing();
    test_sel_switch();
    test_wrap();
    test_clear_edge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
